if_fetch: RTL and testbench

- Instruction-fetch stage. Consumes the program counter from the PC register and fetches one 32-bit instruction as four byte reads through the memory controller's byte-wide port.
- Presents the assembled instruction and its PC to the IF/ID latch.
- Raises a stall request so the PC holds until the fetch completes.
- On a jump/branch redirect it aborts any fetch in flight.

---
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles one 32-bit little-endian instruction from
// four byte reads and hands it to the IF/ID latch, holding the PC until done.
module if_fetch #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pcJump_in,
  output logic              IF_mem_req_out,
  output logic [ADDR_W-1:0] IF_mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [7:0]        mem_data_in,
  output logic [ADDR_W-1:0] IF_pc_out,
  output logic [31:0]       IF_inst_out,
  output logic              IF_valid_out,
  output logic              IF_stallReq_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    F2   = 3'd3,
    F3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   fetch_pc_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [ADDR_W-1:0]   pc_out_r;
  logic [31:0]         inst_buf_r;
  logic [31:0]         inst_out_r;
  logic                mem_req_r;
  logic                done_r;
  logic                unused_stall_s;

  // Only the IF/ID bit of the stall vector matters to this stage.
  assign unused_stall_s = ^{stall_in[STALL_W-1:2], stall_in[0]};

  // Fetch FSM; request/address/done are registered alongside the state so
  // the outputs never glitch, and the delivered word is latched separately
  // so it holds steady while the next fetch refills inst_buf_r.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= IDLE;
      fetch_pc_r <= {ADDR_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
      pc_out_r   <= {ADDR_W{1'b0}};
      inst_buf_r <= 32'h0000_0000;
      inst_out_r <= 32'h0000_0000;
      mem_req_r  <= 1'b0;
      done_r     <= 1'b0;
    end else if (rdy_in) begin
      if (pcJump_in) begin
        state_r    <= IDLE;
        mem_req_r  <= 1'b0;
        mem_addr_r <= {ADDR_W{1'b0}};
        done_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            fetch_pc_r <= pc_in;
            mem_req_r  <= 1'b1;
            mem_addr_r <= pc_in;
            state_r    <= F0;
          end
          F0: begin
            if (mem_ack_in) begin
              inst_buf_r[7:0] <= mem_data_in;
              mem_addr_r      <= fetch_pc_r + ADDR_W'(1);
              state_r         <= F1;
            end
          end
          F1: begin
            if (mem_ack_in) begin
              inst_buf_r[15:8] <= mem_data_in;
              mem_addr_r       <= fetch_pc_r + ADDR_W'(2);
              state_r          <= F2;
            end
          end
          F2: begin
            if (mem_ack_in) begin
              inst_buf_r[23:16] <= mem_data_in;
              mem_addr_r        <= fetch_pc_r + ADDR_W'(3);
              state_r           <= F3;
            end
          end
          F3: begin
            if (mem_ack_in) begin
              inst_buf_r[31:24] <= mem_data_in;
              inst_out_r        <= {mem_data_in, inst_buf_r[23:0]};
              pc_out_r          <= fetch_pc_r;
              mem_req_r         <= 1'b0;
              mem_addr_r        <= {ADDR_W{1'b0}};
              done_r            <= 1'b1;
              state_r           <= DONE;
            end
          end
          DONE: begin
            if (!stall_in[1]) begin
              done_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
          default: begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            done_r     <= 1'b0;
            state_r    <= IDLE;
          end
        endcase
      end
    end
  end

  assign IF_mem_req_out  = mem_req_r;
  assign IF_mem_addr_out = mem_addr_r;
  assign IF_pc_out       = pc_out_r;
  assign IF_inst_out     = inst_out_r;
  // A flush must both kill delivery and release the PC within the same cycle.
  assign IF_valid_out    = done_r & ~pcJump_in;
  assign IF_stallReq_out = ~done_r & ~pcJump_in;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic [31:0] pc_in;
  logic        pcJump_in;
  logic        IF_mem_req_out;
  logic [31:0] IF_mem_addr_out;
  logic        mem_ack_in;
  logic [7:0]  mem_data_in;
  logic [31:0] IF_pc_out;
  logic [31:0] IF_inst_out;
  logic        IF_valid_out;
  logic        IF_stallReq_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: how many bytes collected so far, or idle / delivering.
  bit          m_busy;
  bit          m_deliver;
  int          m_nbytes;
  logic [31:0] m_base;
  logic [7:0]  m_bytes[4];
  logic [31:0] m_inst;
  logic [31:0] m_pc;

  if_fetch #(.ADDR_W(32), .STALL_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .pc_in(pc_in), .pcJump_in(pcJump_in),
    .IF_mem_req_out(IF_mem_req_out), .IF_mem_addr_out(IF_mem_addr_out),
    .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
    .IF_pc_out(IF_pc_out), .IF_inst_out(IF_inst_out),
    .IF_valid_out(IF_valid_out), .IF_stallReq_out(IF_stallReq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_deliver = 1'b0; m_nbytes = 0;
  endtask

  // Drive inputs on the falling edge and compare outputs against the model.
  task automatic step(input logic rdy, input logic jump, input logic st1,
                      input logic [31:0] pc, input logic ack, input logic [7:0] d);
    logic        e_req;
    logic [31:0] e_addr;
    @(negedge clk_in);
    rdy_in = rdy; pcJump_in = jump; stall_in = {4'b0000, st1, 1'b0};
    pc_in = pc; mem_ack_in = ack; mem_data_in = d;
    #1;
    e_req  = m_busy;
    e_addr = m_busy ? m_base + 32'(m_nbytes) : 32'h0;
    check("mem_req", {31'b0, IF_mem_req_out}, {31'b0, e_req});
    check("mem_addr", IF_mem_addr_out, e_addr);
    check("valid", {31'b0, IF_valid_out}, {31'b0, m_deliver && !jump});
    check("stall_req", {31'b0, IF_stallReq_out}, {31'b0, !m_deliver && !jump});
    if (m_deliver) begin
      check("inst", IF_inst_out, m_inst);
      check("pc_out", IF_pc_out, m_pc);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    @(posedge clk_in);
    if (rdy_in) begin
      if (pcJump_in) begin
        model_reset();
      end else if (m_deliver) begin
        if (!stall_in[1]) m_deliver = 1'b0;
      end else if (!m_busy) begin
        m_base = pc_in; m_busy = 1'b1; m_nbytes = 0;
      end else if (mem_ack_in) begin
        m_bytes[m_nbytes] = mem_data_in;
        m_nbytes++;
        if (m_nbytes == 4) begin
          m_inst = 32'h0;
          for (int i = 0; i < 4; i++) m_inst = m_inst + (32'(m_bytes[i]) << (8 * i));
          m_pc = m_base; m_busy = 1'b0; m_deliver = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic rdy, input logic jump, input logic st1,
                     input logic [31:0] pc, input logic ack, input logic [7:0] d);
    step(rdy, jump, st1, pc, ack, d);
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rdy_in = 1'b0; pcJump_in = 1'b0; mem_ack_in = 1'b0;
    rst_in = 1'b0;
    #1;
    model_reset();
    check("rst_req", {31'b0, IF_mem_req_out}, 32'h0);
    check("rst_valid", {31'b0, IF_valid_out}, 32'h0);
    check("rst_stall", {31'b0, IF_stallReq_out}, 32'h1);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; stall_in = 6'h00; pc_in = 32'h0;
    pcJump_in = 1'b0; mem_ack_in = 1'b0; mem_data_in = 8'h00;
    model_reset();
    #3;
    check("rst_req", {31'b0, IF_mem_req_out}, 32'h0);
    check("rst_addr", IF_mem_addr_out, 32'h0);
    check("rst_valid", {31'b0, IF_valid_out}, 32'h0);
    check("rst_stall", {31'b0, IF_stallReq_out}, 32'h1);
    check("rst_inst", IF_inst_out, 32'h0);
    check("rst_pc", IF_pc_out, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Basic fetch, acks back-to-back.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h13);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h05);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 8'h00);
    check("t1_valid", {31'b0, IF_valid_out}, 32'h1);
    check("t1_inst", IF_inst_out, 32'h00100513);
    check("t1_pc", IF_pc_out, 32'h0);
    check("t1_stall", {31'b0, IF_stallReq_out}, 32'h0);
    tick();
    step(1'b1, 1'b0, 1'b0, 32'h1000, 1'b0, 8'h00);
    check("t1_stall_back", {31'b0, IF_stallReq_out}, 32'h1);
    tick();

    // Delayed ack in F2 at 0x1000.
    cyc(1'b1, 1'b0, 1'b0, 32'h1000, 1'b1, 8'hB7);
    cyc(1'b1, 1'b0, 1'b0, 32'h1000, 1'b1, 8'h42);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h1000, 1'b0, 8'hEE);
      check("t2_hold_addr", IF_mem_addr_out, 32'h1002);
      tick();
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h1000, 1'b1, 8'h9A);
    cyc(1'b1, 1'b0, 1'b0, 32'h1000, 1'b1, 8'h01);
    step(1'b1, 1'b0, 1'b0, 32'h1000, 1'b0, 8'h00);
    check("t2_inst", IF_inst_out, 32'h019A42B7);
    tick();

    // Flush during F1 with a simultaneous ack.
    cyc(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 8'h11);
    step(1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 8'h22);
    check("t3_flush_stall", {31'b0, IF_stallReq_out}, 32'h0);
    tick();
    cyc(1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 8'hA0);
    check("t3_new_addr", IF_mem_addr_out, 32'h200);
    tick();
    cyc(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 8'hA1);
    cyc(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 8'hA2);
    cyc(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 8'hA3);
    // IF/ID stalled for 3 cycles on entering DONE.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 8'h00);
      check("t4_valid", {31'b0, IF_valid_out}, 32'h1);
      check("t4_inst", IF_inst_out, 32'hA3A2A1A0);
      tick();
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h204, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'h00);

    // Address wrap.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h03);
    check("t5_wrap_f2", IF_mem_addr_out, 32'h0);
    tick();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'h04);
    check("t5_wrap_f3", IF_mem_addr_out, 32'h1);
    tick();
    cyc(1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 8'h00);

    // rdy low in F1 with ack held, then reset mid-F2.
    cyc(1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 8'h66);
    cyc(1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 8'h88);
    step(1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 8'h00);
    check("t6_f2_addr", IF_mem_addr_out, 32'h302);
    #2;
    rst_in = 1'b0;
    #1;
    check("t6_async_req", {31'b0, IF_mem_req_out}, 32'h0);
    check("t6_async_addr", IF_mem_addr_out, 32'h0);
    model_reset();
    rdy_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
          8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
